// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-queue entry type for the
// instruction-fetch front end.
//   FETCH_XLEN / FETCH_ILEN : default address and instruction widths
//   FETCH_RESET_VECTOR      : PC loaded on reset
//   FETCH_DEPTH             : default fetch-queue depth (max in-flight fetches)
//   fetch_entry_t           : one queue slot {pc, instr, filled}
package fetch_pkg;

  localparam int unsigned FETCH_XLEN         = 32;
  localparam int unsigned FETCH_ILEN         = 32;
  localparam int unsigned FETCH_DEPTH        = 4;
  localparam logic [31:0] FETCH_RESET_VECTOR = 32'h8000_0000;

  // filled=0 means the request is allocated but its instruction has not returned yet
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of fetch entries with three pointers.
//   tail : next slot to allocate when a request is accepted
//   fill : next slot to receive a memory response
//   head : slot presented to decode
// Ports:
//   clk, rst_n            clock, async active-low reset (storage zeroed)
//   flush_i               drop every entry, all pointers return to zero
//   alloc_i, alloc_pc_i   allocate slot at tail with this pc, filled=0
//   wr_i, wr_data_i       write instruction into slot at fill, filled=1
//   pop_i                 consume the head slot
//   head_o                entry at head
//   count_o               allocated entries (tail-head)
//   unfilled_o            allocated entries still waiting for data (tail-fill)
// Entry widths come from fetch_pkg.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [FETCH_XLEN-1:0] alloc_pc_i,
  input  logic                  wr_i,
  input  logic [FETCH_ILEN-1:0] wr_data_i,
  input  logic                  pop_i,
  output fetch_entry_t          head_o,
  output logic [PW:0]           count_o,
  output logic [PW:0]           unfilled_o
);

  // Pointers carry one extra wrap bit so full and empty differ.
  fetch_entry_t entries_q [DEPTH];
  fetch_entry_t entries_d [DEPTH];
  logic [PW:0]  head_q, head_d;
  logic [PW:0]  fill_q, fill_d;
  logic [PW:0]  tail_q, tail_d;

  // Next-state for storage and pointers; flush overrides every other request.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    fill_d    = fill_q;
    tail_d    = tail_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].filled = 1'b0;
      end
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i) begin
        entries_d[head_q[PW-1:0]].filled = 1'b0;
        head_d = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      if (alloc_i) begin
        entries_d[tail_q[PW-1:0]].pc     = alloc_pc_i;
        entries_d[tail_q[PW-1:0]].instr  = '0;
        entries_d[tail_q[PW-1:0]].filled = 1'b0;
        tail_d = tail_q + 1'b1;
      end else begin
        tail_d = tail_q;
      end
      if (wr_i) begin
        entries_d[fill_q[PW-1:0]].instr  = wr_data_i;
        entries_d[fill_q[PW-1:0]].filled = 1'b1;
        fill_d = fill_q + 1'b1;
      end else begin
        fill_d = fill_q;
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      fill_q    <= fill_d;
      tail_q    <= tail_d;
    end
  end

  assign head_o     = entries_q[head_q[PW-1:0]];
  assign count_o    = tail_q - head_q;
  assign unfilled_o = tail_q - fill_q;

endmodule

// File: rtl/fetch_unit_checker.sv
// fetch_unit_checker: protocol and invariant assertions for fetch_unit.
//   rsp_valid    : memory response strobe
//   in_flight    : requests sent to memory and not yet answered
//   count        : fetch-queue occupancy
//   req_addr_lo  : low two bits of the fetch address
module fetch_unit_checker #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rsp_valid,
  input logic [PW+1:0] in_flight,
  input logic [PW:0]   count,
  input logic [1:0]    req_addr_lo
);

  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  a_rsp_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> (in_flight != '0));

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= DEPTH_CNT);

  a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    req_addr_lo == 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues word-aligned
// fetches over a valid/ready request channel, buffers in-order responses with
// their PCs and presents them to decode over valid/ready. A redirect flushes
// the queue and counts still-outstanding responses so they are discarded.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request channel (addr = pc)
//   imem_rsp_valid/data             in-order fetch responses
//   redirect_valid/redirect_pc      taken branch/jump, low two pc bits ignored
//   inst_valid/ready/data/pc        instruction channel to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = FETCH_XLEN,
  parameter int unsigned     ILEN         = FETCH_ILEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter int unsigned     DEPTH        = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_CNT = DEPTH[PW:0];
  localparam logic [PW+1:0] DEPTH_IF  = DEPTH[PW+1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW:0]     drop_q, drop_d;
  logic [PW:0]     count;
  logic [PW:0]     unfilled;
  logic [PW+1:0]   in_flight;
  logic [PW+1:0]   drop_sum;
  fetch_entry_t    head;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_store;
  logic            pop;

  // Everything the memory still owes us: stale responses plus live ones.
  // Capping this at DEPTH keeps drop_q within its width across back-to-back redirects.
  assign in_flight = {1'b0, drop_q} + {1'b0, unfilled};

  // Held low through reset so nothing is offered before release.
  assign imem_req_valid = rst_n && (count < DEPTH_CNT) && (in_flight < DEPTH_IF) && !redirect_valid;
  assign imem_req_addr  = pc_q;

  assign inst_valid = head.filled;
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;

  // Handshake decode, PC and drop-counter next state.
  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    rsp_drop  = imem_rsp_valid && (drop_q != '0);
    rsp_store = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    pop       = inst_valid && inst_ready;
    // On redirect every unanswered request becomes stale; a response arriving
    // now retires one of them immediately, whichever kind it was.
    drop_sum  = in_flight + {{(PW+1){1'b0}}, req_fire} - {{(PW+1){1'b0}}, imem_rsp_valid};
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
      drop_d = drop_sum[PW:0];
    end else begin
      if (req_fire) begin
        pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'b100};
      end else begin
        pc_d = pc_q;
      end
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC and drop-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VECTOR;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .alloc_i    (req_fire),
    .alloc_pc_i (pc_q),
    .wr_i       (rsp_store),
    .wr_data_i  (imem_rsp_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .unfilled_o (unfilled)
  );

  fetch_unit_checker #(
    .DEPTH (DEPTH)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsp_valid   (imem_rsp_valid),
    .in_flight   (in_flight),
    .count       (count),
    .req_addr_lo (imem_req_addr[1:0])
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A behavioural model
// (list of requests owed by memory, list of buffered instructions) predicts
// every output each cycle; directed phases add literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;

  int n_pass = 0;
  int n_total = 0;

  // model state
  logic [31:0] m_pc;
  ent_t        m_q[$];     // instructions the fetch unit should be holding
  bit          m_out[$];   // requests owed by memory; 1 = stale (redirected away)

  // memory environment
  mreq_t       mem_q[$];
  int          cyc = 0;
  int          last_rdy = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // per-cycle drive settings
  bit          d_req_ready = 1'b0;
  bit          d_inst_ready = 1'b0;
  bit          d_redirect = 1'b0;
  logic [31:0] d_redirect_pc = 32'h0;

  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic cycle();
    bit          rsp_v;
    logic [31:0] rsp_d;
    bit          exp_rv;
    bit          exp_iv;
    bit          req_f;
    bit          pop_f;
    bit          stale;
    int          r;
    ent_t        e;
    rsp_v = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
    rsp_d = rsp_v ? mem_fn(mem_q[0].addr) : $urandom;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    imem_req_ready = d_req_ready;
    inst_ready     = d_inst_ready;
    redirect_valid = d_redirect;
    redirect_pc    = d_redirect_pc;
    #2;
    exp_rv = (m_q.size() < DEPTH) && (m_out.size() < DEPTH) && !d_redirect;
    chk1("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    exp_iv = (m_q.size() > 0) && m_q[0].filled;
    chk1("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      chk("inst_data", inst_data, m_q[0].instr);
      chk("inst_pc", inst_pc, m_q[0].pc);
    end
    req_f = exp_rv && d_req_ready;
    pop_f = exp_iv && d_inst_ready;
    if (imem_req_valid && imem_req_ready) begin
      r = cyc + int'($urandom_range(lat_max, lat_min));
      if (r <= last_rdy) r = last_rdy + 1;
      last_rdy = r;
      mem_q.push_back('{imem_req_addr, r});
      acc_log.push_back(imem_req_addr);
    end
    if (rsp_v) void'(mem_q.pop_front());
    if (inst_valid && inst_ready) dlv_log.push_back(inst_pc);
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_v) begin
      if (m_out.size() > 0) stale = m_out.pop_front();
      else stale = 1'b1;
      if (!stale && !d_redirect) begin
        for (int i = 0; i < m_q.size(); i++) begin
          if (!m_q[i].filled) begin
            e = m_q[i];
            e.instr = rsp_d;
            e.filled = 1'b1;
            m_q[i] = e;
            break;
          end
        end
      end
    end
    if (pop_f) void'(m_q.pop_front());
    if (req_f) begin
      m_q.push_back('{m_pc, 32'h0, 1'b0});
      m_out.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (d_redirect) begin
      foreach (m_out[i]) m_out[i] = 1'b1;
      m_q.delete();
      m_pc = d_redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  // Assert reset, check reset outputs, clear model and memory, release at posedge+1.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    repeat (2) @(posedge clk);
    m_q.delete();
    m_out.delete();
    mem_q.delete();
    acc_log.delete();
    dlv_log.delete();
    m_pc = 32'h8000_0000;
    last_rdy = cyc;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;

    // 1: streaming with single-cycle memory
    do_reset();
    d_req_ready = 1'b1; d_inst_ready = 1'b1; d_redirect = 1'b0; lat_min = 1; lat_max = 1;
    chk("t1_first_addr", imem_req_addr, 32'h8000_0000);
    repeat (12) cycle();
    chk("t1_acc0", acc_log[0], 32'h8000_0000);
    chk("t1_acc1", acc_log[1], 32'h8000_0004);
    chk("t1_acc2", acc_log[2], 32'h8000_0008);
    chk("t1_acc3", acc_log[3], 32'h8000_000C);
    chk("t1_delivered", dlv_log.size(), 32'd10);
    chk("t1_dlv0", dlv_log[0], 32'h8000_0000);
    chk("t1_dlv9", dlv_log[9], 32'h8000_0024);

    // 2: decode backpressure fills the queue
    do_reset();
    d_inst_ready = 1'b0;
    repeat (10) cycle();
    chk("t2_accepted", acc_log.size(), 32'd4);
    chk1("t2_req_valid_low", imem_req_valid, 1'b0);
    d_inst_ready = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) chk("t2_order", dlv_log[i], 32'h8000_0000 + 32'(4 * i));

    // 3: 3-cycle memory, toggling request ready, random decode stalls
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 150; i++) begin
      d_req_ready  = ($urandom_range(1, 0) == 1);
      d_inst_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end
    d_req_ready = 1'b0; d_inst_ready = 1'b1;
    repeat (12) cycle();
    chk("t3_no_loss", dlv_log.size(), acc_log.size());
    for (int i = 0; i < dlv_log.size(); i++) chk("t3_seq", dlv_log[i], 32'h8000_0000 + 32'(4 * i));

    // 4: redirect with three fetches in flight
    do_reset();
    lat_min = 5; lat_max = 5; d_req_ready = 1'b1; d_inst_ready = 1'b1;
    repeat (3) cycle();
    d_redirect = 1'b1; d_redirect_pc = 32'h8000_0103;
    cycle();
    d_redirect = 1'b0;
    chk("t4_addr", imem_req_addr, 32'h8000_0100);
    repeat (20) cycle();
    chk("t4_acc3", acc_log[3], 32'h8000_0100);
    chk("t4_first_pc", dlv_log[0], 32'h8000_0100);

    // 5: redirect in a cycle carrying a live response
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    d_redirect = 1'b1; d_redirect_pc = 32'h8000_0200;
    cycle();
    d_redirect = 1'b0;
    chk("t5_consumed", dlv_log.size(), 32'd5);
    repeat (6) cycle();
    chk("t5_last_old", dlv_log[4], 32'h8000_0010);
    chk("t5_first_new", dlv_log[5], 32'h8000_0200);

    // 6: PC wrap, then reset mid-burst
    do_reset();
    repeat (2) cycle();
    d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFFC;
    cycle();
    d_redirect = 1'b0;
    chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    repeat (3) cycle();
    do_reset();
    repeat (3) cycle();
    chk("t6_restart", acc_log[0], 32'h8000_0000);

    // random soak with redirects and variable latency
    do_reset();
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 3000; i++) begin
      d_req_ready   = ($urandom_range(9, 0) < 7);
      d_inst_ready  = ($urandom_range(9, 0) < 6);
      d_redirect    = ($urandom_range(31, 0) == 0);
      d_redirect_pc = $urandom;
      cycle();
    end
    d_redirect = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
